// File: rtl/muldiv_seq_unit_if.sv
// muldiv_seq_unit_if: EX-stage request and HI/LO result bundle for the multiply/divide sequencer
interface muldiv_seq_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             req_mf;
    logic             flush;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             stall;
    logic             done;
    modport master (output start, Funct, OpA, OpB, req_mf, flush, input HI, LO, busy, stall, done);
    modport slave (input start, Funct, OpA, OpB, req_mf, flush, output HI, LO, busy, stall, done);
endinterface

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and pipeline stall
module muldiv_seq_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    muldiv_seq_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d, a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, neg_q, neg_d, neg_a_q, neg_a_d, zero_q, zero_d, done_q, done_d;
    logic               is_signed, is_mul, is_div, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum, dshift, ddiff;
    logic [2*WIDTH-1:0] prod;
    assign is_signed = ~bus.Funct[0];
    assign is_mul = bus.Funct[5:1] == 5'b01100;
    assign is_div = bus.Funct[5:1] == 5'b01101;
    assign sa = is_signed & bus.OpA[WIDTH-1];
    assign sb = is_signed & bus.OpB[WIDTH-1];
    assign abs_a = sa ? -bus.OpA : bus.OpA;
    assign abs_b = sb ? -bus.OpB : bus.OpB;
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? b_q : {WIDTH{1'b0}}};
    // Divide: acc = {remainder, dividend/quotient bits}, shifted left each step
    assign dshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ddiff = dshift - {1'b0, b_q};
    assign prod = neg_q ? -acc_q : acc_q;
    assign bus.HI = hi_q;
    assign bus.LO = lo_q;
    assign bus.done = done_q;
    assign bus.busy = state_q != IDLE;
    assign bus.stall = bus.busy & (bus.start | bus.req_mf);
    // Next-state: accept ops in IDLE, iterate in RUN, sign-fix and write HI/LO in FIX; flush aborts
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        b_d = b_q;
        a_raw_d = a_raw_q;
        hi_d = hi_q;
        lo_d = lo_q;
        div_d = div_q;
        neg_d = neg_q;
        neg_a_d = neg_a_q;
        zero_d = zero_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start & ~bus.flush) begin
                if (bus.Funct == 6'b010001) hi_d = bus.OpA;
                if (bus.Funct == 6'b010011) lo_d = bus.OpA;
                if (is_mul | is_div) begin
                    state_d = RUN;
                    cnt_d = '0;
                    acc_d = {{WIDTH{1'b0}}, abs_a};
                    b_d = abs_b;
                    a_raw_d = bus.OpA;
                    div_d = is_div;
                    neg_d = sa ^ sb;
                    neg_a_d = sa;
                    zero_d = bus.OpB == '0;
                end
            end
        end else if (bus.flush) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            acc_d = div_q ? {ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], ~ddiff[WIDTH]}
                          : {msum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end else begin
            state_d = IDLE;
            done_d = 1'b1;
            hi_d = !div_q ? prod[2*WIDTH-1:WIDTH] : zero_q ? a_raw_q
                 : neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = !div_q ? prod[WIDTH-1:0] : zero_q ? {WIDTH{1'b1}}
                 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end
    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            b_q <= '0;
            a_raw_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_a_q <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            b_q <= b_d;
            a_raw_q <= a_raw_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            div_q <= div_d;
            neg_q <= neg_d;
            neg_a_q <= neg_a_d;
            zero_q <= zero_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: scoreboard bench for the multiply/divide sequencer
module tb_muldiv_seq_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    muldiv_seq_unit_if #(.WIDTH(32)) bus();
    muldiv_seq_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.Funct = f;
        bus.OpA = a;
        bus.OpB = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        int n = 0;
        exp_q.push_back({hi, lo});
        issue(f, a, b);
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        check({name, " busy_cycles"}, 64'(n), 64'd33);
        check({name, " done_pulse"}, 64'(bus.done), 64'd1);
        tick();
        check({name, " done_clear"}, 64'(bus.done), 64'd0);
    endtask

    // Monitor: every done pulse pops the oldest expected HI/LO pair
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got HI=%h LO=%h expected no done", bus.HI, bus.LO);
            end else begin
                check("scoreboard HI:LO", {bus.HI, bus.LO}, exp_q.pop_front());
            end
        end
    end

    initial begin
        int sc;
        int dc;
        bus.start = 1'b0;
        bus.Funct = '0;
        bus.OpA = '0;
        bus.OpB = '0;
        bus.req_mf = 1'b0;
        bus.flush = 1'b0;
        repeat (3) tick();
        check("reset HI:LO", {bus.HI, bus.LO}, 64'd0);
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        rst_n = 1'b1;
        tick();
        run_op("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 6'b011000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu_100_7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_by0", 6'b011011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_by0", 6'b011010, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        run_op("mult_pos", 6'b011000, 32'd123456, 32'd1000, 32'd0, 32'd123456000);
        issue(6'b010001, 32'hA5A5_A5A5, 32'd0);
        check("mthi HI", 64'(bus.HI), 64'hA5A5_A5A5);
        check("mthi busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.flush = 1'b1;
        issue(6'b010001, 32'h1111_1111, 32'd0);
        bus.flush = 1'b0;
        check("mthi_flushed HI", 64'(bus.HI), 64'hA5A5_A5A5);
        issue(6'b010011, 32'h0000_1234, 32'd0);
        check("mtlo LO", 64'(bus.LO), 64'h1234);
        dc = done_cnt;
        issue(6'b011001, 32'd9, 32'd9);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush HI:LO", {bus.HI, bus.LO}, {32'hA5A5_A5A5, 32'h0000_1234});
        repeat (40) tick();
        check("flush no_done", 64'(done_cnt), 64'(dc));
        exp_q.push_back({32'd0, 32'd12});
        issue(6'b011001, 32'd3, 32'd4);
        sc = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c >= 5) bus.req_mf = 1'b1;
            #1;
            if (bus.stall) sc++;
            tick();
        end
        check("stall cycles", 64'(sc), 64'd29);
        check("done_cycle done/stall", {62'd0, bus.done, bus.stall}, 64'd2);
        bus.req_mf = 1'b0;
        tick();
        dc = done_cnt;
        issue(6'b011001, 32'd3, 32'd4);
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        check("midop_reset HI:LO", {bus.HI, bus.LO}, 64'd0);
        check("midop_reset busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        check("midop_reset no_done", 64'(done_cnt), 64'(dc));
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
